// File: rtl/dram_refresh_pkg.sv
// Shared constants and types for the DRAM refresh scheduler.
// The rank state enum is a debug/assertion view of a pending count.
package dram_refresh_pkg;

  localparam int CNT_W_DEF          = 24;
  localparam int NUM_RANKS_DEF      = 2;
  localparam int MAX_PEND_DEF       = 8;
  localparam int URGENT_THR_DEF     = 6;
  localparam int PEND_W_DEF         = 4;
  localparam int tREFI_7P8US_150MHZ = 1170;

  typedef enum logic [1:0] {
    RANK_IDLE      = 2'd0,
    RANK_OWED      = 2'd1,
    RANK_URGENT    = 2'd2,
    RANK_SATURATED = 2'd3
  } rank_state_e;

  function automatic rank_state_e rank_state(input int pend, input int max_pend, input int urg_thr);
    rank_state_e st;
    if (pend == 0) begin
      st = RANK_IDLE;
    end else if (pend >= max_pend) begin
      st = RANK_SATURATED;
    end else if (pend >= urg_thr) begin
      st = RANK_URGENT;
    end else begin
      st = RANK_OWED;
    end
    return st;
  endfunction

endpackage

// File: rtl/refresh_scheduler_credit.sv
// One rank's pending-refresh credit: saturating counter, sticky overflow,
// and registered req/urgent decodes that track the counter cycle for cycle.
module refresh_credit
  import dram_refresh_pkg::*;
#(
  parameter int MAX_PEND   = MAX_PEND_DEF,
  parameter int URGENT_THR = URGENT_THR_DEF,
  parameter int PEND_W     = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              tick_i,
  input  logic              ack_i,
  output logic [PEND_W-1:0] pending_o,
  output logic              req_o,
  output logic              urgent_o,
  output logic              overflow_o
);

  localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_URG  = PEND_W'(URGENT_THR);

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              req_q, urgent_q;

  // A tick and an ack in the same cycle cancel each other out.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    case ({tick_i, ack_i})
      2'b10: begin
        if (pend_q == PEND_MAX) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + PEND_ONE;
        end
      end
      2'b01: begin
        if (pend_q != PEND_ZERO) begin
          pend_d = pend_q - PEND_ONE;
        end else begin
          pend_d = pend_q;
        end
      end
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend_q   <= PEND_ZERO;
      ovf_q    <= 1'b0;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      req_q    <= (pend_d != PEND_ZERO);
      urgent_q <= (pend_d >= PEND_URG);
    end
  end

  assign pending_o  = pend_q;
  assign req_o      = req_q;
  assign urgent_o   = urgent_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/refresh_scheduler.sv
// Programmable tREFI interval timer feeding one postponement credit counter
// per rank; the scheduler drains credits through ref_ack.
module refresh_scheduler
  import dram_refresh_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NUM_RANKS  = NUM_RANKS_DEF,
  parameter int MAX_PEND   = MAX_PEND_DEF,
  parameter int URGENT_THR = URGENT_THR_DEF,
  parameter int PEND_W     = PEND_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        en,
  input  logic [CNT_W-1:0]            interval,
  input  logic [NUM_RANKS-1:0]        ref_ack,
  output logic [NUM_RANKS-1:0]        ref_req,
  output logic [NUM_RANKS-1:0]        ref_urgent,
  output logic [NUM_RANKS*PEND_W-1:0] pending,
  output logic                        tick,
  output logic [NUM_RANKS-1:0]        overflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] last_s;
  logic             tick_q, tick_d;

  // Intervals of 0 and 1 both mean a tick every enabled cycle; using >=
  // lets a shrunk interval fire immediately instead of wrapping.
  always_comb begin
    last_s  = (interval <= CNT_ONE) ? CNT_ZERO : (interval - CNT_ONE);
    count_d = count_q;
    tick_d  = 1'b0;
    if (en) begin
      if (count_q >= last_s) begin
        tick_d  = 1'b1;
        count_d = CNT_ZERO;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      count_d = count_q;
      tick_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= CNT_ZERO;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    refresh_credit #(
      .MAX_PEND   (MAX_PEND),
      .URGENT_THR (URGENT_THR),
      .PEND_W     (PEND_W)
    ) u_credit (
      .clk        (clk),
      .rst_b      (rst_b),
      .tick_i     (tick_q),
      .ack_i      (ref_ack[r]),
      .pending_o  (pending[r*PEND_W +: PEND_W]),
      .req_o      (ref_req[r]),
      .urgent_o   (ref_urgent[r]),
      .overflow_o (overflow[r])
    );
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler: vector table, hand sequences for
// timing corners, and randomized traffic against a behavioural model.
module tb_refresh_scheduler;

  logic        clk;
  logic        rst_b;
  logic        en;
  logic [23:0] interval;
  logic [1:0]  ref_ack;
  logic [1:0]  ref_req;
  logic [1:0]  ref_urgent;
  logic [7:0]  pending;
  logic        tick;
  logic [1:0]  overflow;

  refresh_scheduler dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .en         (en),
    .interval   (interval),
    .ref_ack    (ref_ack),
    .ref_req    (ref_req),
    .ref_urgent (ref_urgent),
    .pending    (pending),
    .tick       (tick),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks_seen = 0;

  // Behavioural model: elapsed-cycle count, last tick, credits per rank.
  int m_count;
  int m_tick;
  int m_pend [2];
  int m_ovf  [2];

  typedef struct {
    logic        en;
    logic [23:0] iv;
    logic [1:0]  ack;
    int          n;
    logic [7:0]  exp_pend;
    logic [1:0]  exp_req;
    logic [1:0]  exp_urg;
    logic [1:0]  exp_ovf;
    int          exp_ticks;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_tick  = 0;
    for (int r = 0; r < 2; r++) begin
      m_pend[r] = 0;
      m_ovf[r]  = 0;
    end
  endtask

  task automatic model_update(input logic e, input logic [23:0] iv, input logic [1:0] a);
    int period;
    int new_tick;
    new_tick = 0;
    if (e) begin
      period = (iv == 24'd0) ? 1 : int'(iv);
      if (m_count + 1 >= period) begin
        new_tick = 1;
        m_count  = 0;
      end else begin
        m_count = m_count + 1;
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (m_tick == 1 && !a[r]) begin
        if (m_pend[r] == 8) m_ovf[r] = 1;
        else m_pend[r] = m_pend[r] + 1;
      end else if (m_tick == 0 && a[r] && m_pend[r] > 0) begin
        m_pend[r] = m_pend[r] - 1;
      end
    end
    m_tick = new_tick;
  endtask

  // Inputs change at the falling edge; outputs checked at the next falling edge.
  task automatic step(input logic e, input logic [23:0] iv, input logic [1:0] a);
    logic [14:0] exp_v;
    en = e;
    interval = iv;
    ref_ack = a;
    @(posedge clk);
    model_update(e, iv, a);
    @(negedge clk);
    exp_v = {m_tick[0], 4'(m_pend[1]), 4'(m_pend[0]),
             (m_pend[1] != 0), (m_pend[0] != 0),
             (m_pend[1] >= 6), (m_pend[0] >= 6),
             m_ovf[1][0], m_ovf[0][0]};
    check("model", {17'd0, tick, pending, ref_req, ref_urgent, overflow}, {17'd0, exp_v});
    if (tick) ticks_seen++;
  endtask

  task automatic run_row(input int i);
    ticks_seen = 0;
    for (int c = 0; c < tbl[i].n; c++) step(tbl[i].en, tbl[i].iv, tbl[i].ack);
    ref_ack = 2'b00;
    check($sformatf("row%0d_pend", i), {24'd0, pending}, {24'd0, tbl[i].exp_pend});
    check($sformatf("row%0d_req", i), {30'd0, ref_req}, {30'd0, tbl[i].exp_req});
    check($sformatf("row%0d_urg", i), {30'd0, ref_urgent}, {30'd0, tbl[i].exp_urg});
    check($sformatf("row%0d_ovf", i), {30'd0, overflow}, {30'd0, tbl[i].exp_ovf});
    check($sformatf("row%0d_ticks", i), ticks_seen, tbl[i].exp_ticks);
  endtask

  initial begin
    int waited;
    logic [23:0] riv;

    tbl[0] = '{1'b1, 24'd10, 2'b00, 35, 8'h33, 2'b11, 2'b00, 2'b00, 3};
    tbl[1] = '{1'b0, 24'd10, 2'b01, 3,  8'h30, 2'b10, 2'b00, 2'b00, 0};
    tbl[2] = '{1'b0, 24'd10, 2'b01, 1,  8'h30, 2'b10, 2'b00, 2'b00, 0};
    tbl[3] = '{1'b1, 24'd4,  2'b00, 40, 8'h88, 2'b11, 2'b11, 2'b11, 10};
    tbl[4] = '{1'b0, 24'd4,  2'b11, 2,  8'h66, 2'b11, 2'b11, 2'b11, 0};
    tbl[5] = '{1'b0, 24'd4,  2'b11, 1,  8'h55, 2'b11, 2'b00, 2'b11, 0};

    rst_b = 1'b0;
    en = 1'b0;
    interval = 24'd0;
    ref_ack = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outs", {23'd0, tick, pending, ref_req, ref_urgent, overflow}, 32'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 3; i++) run_row(i);

    // Tick and ack coincide on rank 1: credit unchanged; rank 0 gains one.
    waited = 0;
    while (tick !== 1'b1 && waited < 20) begin
      step(1'b1, 24'd10, 2'b00);
      waited++;
    end
    check("tick_wait", waited, 5);
    step(1'b1, 24'd10, 2'b10);
    check("tick_ack_pend", {24'd0, pending}, {24'd0, 8'h31});

    for (int i = 3; i < 6; i++) run_row(i);

    // Shrink the interval below the running count: tick on the next cycle.
    for (int c = 0; c < 49; c++) step(1'b1, 24'd100, 2'b00);
    check("pre_shrink_tick", {31'd0, tick}, 32'd0);
    step(1'b1, 24'd20, 2'b00);
    check("shrink_tick", {31'd0, tick}, 32'd1);
    ticks_seen = 0;
    for (int c = 0; c < 19; c++) step(1'b1, 24'd20, 2'b00);
    check("period20_quiet", ticks_seen, 0);
    step(1'b1, 24'd20, 2'b00);
    check("period20_tick", {31'd0, tick}, 32'd1);

    ticks_seen = 0;
    for (int c = 0; c < 30; c++) step(1'b0, 24'd20, (c == 1 || c == 2) ? 2'b11 : 2'b00);
    check("en_off_ticks", ticks_seen, 0);
    check("en_off_pend", {24'd0, pending}, {24'd0, 8'h55});
    ticks_seen = 0;
    for (int c = 0; c < 19; c++) step(1'b1, 24'd20, 2'b00);
    check("frozen_quiet", ticks_seen, 0);
    step(1'b1, 24'd20, 2'b00);
    check("frozen_tick", {31'd0, tick}, 32'd1);

    step(1'b1, 24'd20, 2'b11);
    for (int c = 0; c < 4; c++) step(1'b1, 24'd20, 2'b00);
    check("pre_reset_pend", {24'd0, pending}, {24'd0, 8'h55});

    // Asynchronous reset between clock edges.
    #2 rst_b = 1'b0;
    #1 check("async_reset", {23'd0, tick, pending, ref_req, ref_urgent, overflow}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    ticks_seen = 0;
    for (int c = 0; c < 6; c++) step(1'b1, 24'd7, 2'b00);
    check("post_reset_quiet", ticks_seen, 0);
    step(1'b1, 24'd7, 2'b00);
    check("post_reset_tick", {31'd0, tick}, 32'd1);

    riv = 24'd3;
    for (int c = 0; c < 600; c++) begin
      if (c % 16 == 0) riv = 24'($urandom_range(0, 6));
      step(($urandom_range(0, 9) != 0), riv,
           ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
